oled_cmd_dispatcher: RTL and testbench

Downstream stage of the command compiler. Holds the 8-entry, 96-bit drawing-command table that the compiler writes through its WE_bar/Addr/DataOut port. On a start request it walks entries 0..7 and serializes each valid entry into the SSD1331 byte sequence. Bytes go over a valid/ready stream to the SPI shifter, with a programmable settle delay after each command.

---
 rtl/oled_cmd_dispatcher.sv | 173 +++++++++++++++++
 tb/tb_oled_cmd_dispatcher.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_cmd_dispatcher.sv
// Drawing-command table plus dispatcher: walks every entry on a start edge and
// serializes each valid entry into SSD1331 command bytes over a valid/ready stream.
module oled_cmd_dispatcher #(
  parameter int ENTRIES     = 8,
  parameter int WAIT_CYCLES = 1000,
  localparam int AW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          WE_bar,
  input  logic [AW-1:0] Addr,
  input  logic [95:0]   DataIn,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [7:0]    tx_data,
  output logic          tx_dc,
  output logic          tx_valid,
  input  logic          tx_ready
);

  localparam int WW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  // Stream handshake: a byte moves on the rising edge where tx_valid && tx_ready.
  // tx_valid/tx_data are registered; once tx_valid rises, tx_data holds and
  // tx_valid stays high until that byte is taken.

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FILL0,
    S_FILL1,
    S_SEND,
    S_WAIT,
    S_NEXT
  } state_t;

  state_t        state;
  logic [95:0]   table_q [ENTRIES];
  logic [95:0]   shadow;
  logic [AW-1:0] index;
  logic [3:0]    k;
  logic [3:0]    n_bytes;
  logic [WW-1:0] wait_cnt;
  logic          start_q;

  logic [95:0]   cur;
  logic [3:0]    cur_code;
  logic [3:0]    cur_n;
  logic          xfer;

  function automatic logic [3:0] byte_count(input logic [3:0] code);
    case (code)
      4'd1:    return 4'd5;
      4'd2:    return 4'd7;
      4'd3:    return 4'd8;
      4'd4:    return 4'd11;
      default: return 4'd0;
    endcase
  endfunction

  // Byte idx counts from the opcode at [87:80] downwards in 8-bit steps.
  function automatic logic [7:0] byte_at(input logic [95:0] e, input logic [3:0] idx);
    logic [6:0]  lo;
    logic [95:0] sh;
    lo = 7'd80 - {idx, 3'b000};
    sh = e >> lo;
    return sh[7:0];
  endfunction

  assign cur      = table_q[index];
  assign cur_code = cur[91:88];
  assign cur_n    = byte_count(cur_code);
  assign xfer     = tx_valid && tx_ready;
  assign tx_dc    = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= '0;
    end else if (!WE_bar && int'(Addr) < ENTRIES) begin
      table_q[Addr] <= DataIn;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      shadow   <= '0;
      index    <= '0;
      k        <= '0;
      n_bytes  <= '0;
      wait_cnt <= '0;
      start_q  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      start_q <= start;
      done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !start_q) begin
            busy  <= 1'b1;
            index <= '0;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          shadow   <= cur;
          n_bytes  <= cur_n;
          k        <= '0;
          wait_cnt <= '0;
          if (cur_n == 4'd0) begin
            state <= S_NEXT;
          end else if (cur_code == 4'd4) begin
            tx_data  <= 8'h26;
            tx_valid <= 1'b1;
            state    <= S_FILL0;
          end else begin
            tx_data  <= cur[87:80];
            tx_valid <= 1'b1;
            state    <= S_SEND;
          end
        end
        S_FILL0: begin
          if (xfer) begin
            tx_data <= {7'b0, shadow[92]};
            state   <= S_FILL1;
          end
        end
        S_FILL1: begin
          if (xfer) begin
            tx_data <= shadow[87:80];
            state   <= S_SEND;
          end
        end
        S_SEND: begin
          if (xfer) begin
            if (k == n_bytes - 4'd1) begin
              tx_valid <= 1'b0;
              wait_cnt <= '0;
              state    <= S_WAIT;
            end else begin
              k       <= k + 4'd1;
              tx_data <= byte_at(shadow, k + 4'd1);
            end
          end
        end
        S_WAIT: begin
          // WAIT_CYCLES of 0 or 1 both spend exactly one cycle here.
          if (WAIT_CYCLES <= 1 || wait_cnt == WW'(WAIT_CYCLES - 1)) begin
            state <= S_NEXT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_NEXT: begin
          if (index == AW'(ENTRIES - 1)) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            index <= index + 1'b1;
            state <= S_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_cmd_dispatcher.sv
// Directed bench for oled_cmd_dispatcher: byte sequences, back-pressure, skipping,
// inter-command gap and asynchronous abort, all against hand-computed vectors.
module tb_oled_cmd_dispatcher;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        WE_bar = 1'b1;
  logic [2:0]  Addr = '0;
  logic [95:0] DataIn = '0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic [7:0]  tx_data;
  logic        tx_dc;
  logic        tx_valid;
  logic        tx_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         xfer_t[$];
  int         cyc_n = 0;
  int         done_cnt = 0;
  int         valid_seen = 0;
  int         dc_bad = 0;

  oled_cmd_dispatcher #(.ENTRIES(8), .WAIT_CYCLES(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .WE_bar   (WE_bar),
    .Addr     (Addr),
    .DataIn   (DataIn),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .tx_data  (tx_data),
    .tx_dc    (tx_dc),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Inputs change 1 time unit after posedge; outputs are sampled on negedge.
  always @(negedge clk) begin
    cyc_n++;
    if (tx_valid && tx_ready) begin
      got_q.push_back(tx_data);
      xfer_t.push_back(cyc_n);
      if (tx_dc !== 1'b0) dc_bad++;
    end
    if (done) done_cnt++;
    if (tx_valid) valid_seen++;
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; WE_bar = 1'b1; start = 1'b0; tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic write_entry(input logic [2:0] a, input logic [95:0] d);
    @(posedge clk); #1;
    WE_bar = 1'b0; Addr = a; DataIn = d;
    @(posedge clk); #1;
    WE_bar = 1'b1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic clear_scoreboard();
    got_q.delete(); xfer_t.delete(); exp_q.delete();
    done_cnt = 0; valid_seen = 0; dc_bad = 0;
  endtask

  task automatic wait_idle(input string tag, output int cyc);
    cyc = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy) break;
      cyc++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_timeout busy=%b after %0d cycles, required 0", tag, busy, cyc);
    end
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_data got %h exp 00", tx_data); end
    checks++; if (tx_dc !== 1'b0) begin errors++; $display("FAIL rst_dc got %b exp 0", tx_dc); end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_clear_cmd();
    int lat;
    int cyc;
    do_reset();
    clear_scoreboard();
    write_entry(3'd0, 96'h01_25_00_00_5F_3F_00_00_00_00_00_00);
    exp_q = '{8'h25, 8'h00, 8'h00, 8'h5F, 8'h3F};
    pulse_start();
    lat = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_valid) break;
      lat++;
    end
    checks++;
    if (lat > 3) begin errors++; $display("FAIL clr_latency got %0d clocks exp <=3", lat); end
    wait_idle("clr", cyc);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL clr_len got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL clr_byte%0d got %h exp %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++; if (dc_bad != 0) begin errors++; $display("FAIL clr_dc got %0d bad bytes exp 0", dc_bad); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL clr_done got %0d pulses exp 1", done_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_busy_after got %b exp 0", busy); end
  endtask

  task automatic test_rect_fill();
    int cyc;
    do_reset();
    clear_scoreboard();
    write_entry(3'd3, 96'h14_22_10_10_40_20_FF_00_00_FF_00_00);
    exp_q = '{8'h26, 8'h01, 8'h22, 8'h10, 8'h10, 8'h40, 8'h20, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00};
    pulse_start();
    wait_idle("rect1", cyc);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rect1_len got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rect1_byte%0d got %h exp %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    clear_scoreboard();
    write_entry(3'd3, 96'h04_22_10_10_40_20_FF_00_00_FF_00_00);
    exp_q = '{8'h26, 8'h00, 8'h22, 8'h10, 8'h10, 8'h40, 8'h20, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00};
    pulse_start();
    wait_idle("rect0", cyc);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rect0_len got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rect0_byte%0d got %h exp %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL rect0_done got %0d exp 1", done_cnt); end
  endtask

  task automatic test_backpressure();
    int hs;
    int cyc;
    do_reset();
    clear_scoreboard();
    write_entry(3'd0, 96'h01_25_00_00_5F_3F_00_00_00_00_00_00);
    exp_q = '{8'h25, 8'h00, 8'h00, 8'h5F, 8'h3F};
    pulse_start();
    hs = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_valid && tx_ready) hs++;
      if (hs == 2) break;
    end
    @(posedge clk); #1 tx_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin
        errors++; $display("FAIL bp_hold%0d got valid=%b data=%h exp valid=1 data=00", i, tx_valid, tx_data);
      end
    end
    @(posedge clk); #1 tx_ready = 1'b1;
    wait_idle("bp", cyc);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL bp_len got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL bp_byte%0d got %h exp %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done got %0d exp 1", done_cnt); end
  endtask

  task automatic test_skip_all();
    int cyc;
    do_reset();
    clear_scoreboard();
    pulse_start();
    wait_idle("skip", cyc);
    // Eight skipped entries, two cycles (LOAD, NEXT) each.
    checks++; if (cyc != 16) begin errors++; $display("FAIL skip_busy_cycles got %0d exp 16", cyc); end
    checks++; if (valid_seen != 0) begin errors++; $display("FAIL skip_valid got %0d cycles exp 0", valid_seen); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL skip_done got %0d exp 1", done_cnt); end
    clear_scoreboard();
    pulse_start();
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_idle("skip2", cyc);
    repeat (30) @(negedge clk);
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL skip_restart_done got %0d exp 1", done_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL skip_restart_busy got %b exp 0", busy); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    do_reset();
    clear_scoreboard();
    write_entry(3'd0, 96'h03_21_01_02_03_04_AA_BB_CC_00_00_00);
    write_entry(3'd1, 96'h02_23_05_06_07_08_09_0A_00_00_00_00);
    exp_q = '{8'h21, 8'h01, 8'h02, 8'h03, 8'h04, 8'hAA, 8'hBB, 8'hCC,
              8'h23, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
    pulse_start();
    // Overwriting entry 0 while it is in flight must not disturb its bytes.
    write_entry(3'd0, 96'h01_FF_EE_EE_EE_EE_00_00_00_00_00_00);
    wait_idle("b2b", cyc);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL b2b_len got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL b2b_byte%0d got %h exp %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    // Gap = 4 wait clocks + NEXT + LOAD, so transfers are 7 clocks apart.
    if (xfer_t.size() >= 9) begin
      checks++;
      if (xfer_t[8] - xfer_t[7] != 7) begin
        errors++; $display("FAIL b2b_gap got %0d clocks exp 7", xfer_t[8] - xfer_t[7]);
      end
      checks++;
      if (xfer_t[1] - xfer_t[0] != 1) begin
        errors++; $display("FAIL b2b_stream got %0d clocks exp 1", xfer_t[1] - xfer_t[0]);
      end
    end else begin
      checks++; errors++;
      $display("FAIL b2b_xfers got %0d transfers exp 15", xfer_t.size());
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL b2b_done got %0d exp 1", done_cnt); end
  endtask

  task automatic test_abort();
    int hs;
    int cyc;
    do_reset();
    clear_scoreboard();
    write_entry(3'd3, 96'h14_22_10_10_40_20_FF_00_00_FF_00_00);
    exp_q = '{8'h26, 8'h01, 8'h22};
    pulse_start();
    hs = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_valid && tx_ready) hs++;
      if (hs == 3) break;
    end
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b exp 0", tx_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL abort_data got %h exp 00", tx_data); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort_done got %0d exp 0", done_cnt); end
    checks++;
    if (got_q.size() != 3) begin
      errors++; $display("FAIL abort_len got %0d exp 3", got_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL abort_byte%0d got %h exp %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    valid_seen = 0;
    pulse_start();
    wait_idle("abort_restart", cyc);
    checks++; if (valid_seen != 0) begin errors++; $display("FAIL abort_restart_valid got %0d exp 0", valid_seen); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL abort_restart_done got %0d exp 1", done_cnt); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_clear_cmd();
    test_rect_fill();
    test_backpressure();
    test_skip_all();
    test_back_to_back();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
